// File: rtl/debounced_input_dev_if.sv
// Bus interface between the MEM stage and a debounced input bank.
// The master (CPU) drives address, store data and strobes; the slave
// returns combinational read data.
interface debounced_input_dev_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        output re,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  re,
        output rdata
    );
endinterface

// File: rtl/debounced_input_dev.sv
// Memory-mapped debounced input bank (KEY/SW) for the pipelined CPU.
// Raw pins are synchronised, sampled every DEB_CYCLES clocks and a channel
// only changes in DATA once two consecutive samples agree. Three registers
// are exposed: DATA (RO), CTRL (READY/OVERRUN/IE) and EDGE (sticky rises, W1C).
module debounced_input_dev #(
    parameter int unsigned      DBITS      = 32,
    parameter int unsigned      NCH        = 4,
    parameter logic [DBITS-1:0] BASE       = 32'hFFFFF080,
    parameter int unsigned      DEB_CYCLES = 16,
    parameter bit               ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    debounced_input_dev_if.slave        bus,
    input  logic [NCH-1:0]              pins,
    output logic                        intr
);

    localparam int unsigned      CW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [DBITS-1:0] ADDR_DATA = BASE;
    localparam logic [DBITS-1:0] ADDR_CTRL = BASE + DBITS'(4);
    localparam logic [DBITS-1:0] ADDR_EDGE = BASE + DBITS'(8);

    // CTRL bit positions
    localparam int unsigned CTRL_READY = 0;
    localparam int unsigned CTRL_OVR   = 2;
    localparam int unsigned CTRL_IE    = 8;

    // Input path
    logic [NCH-1:0] pins_in;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick;
    logic [NCH-1:0] sample_q, sample_d;
    logic [NCH-1:0] data_q, data_d;
    logic [NCH-1:0] upd;
    logic [NCH-1:0] rise;
    logic           change;

    // Register file
    logic [NCH-1:0] edge_q, edge_d;
    logic           ready_q, ready_d;
    logic           ovr_q, ovr_d;
    logic           ie_q, ie_d;
    logic           intr_q, intr_d;

    // Bus decode
    logic           sel_data, sel_ctrl, sel_edge;
    logic           rd_data, wr_ctrl, wr_edge;
    logic [DBITS-1:0] rdata_c;
    logic           unused_wdata;

    assign pins_in = ACTIVE_LOW ? ~pins : pins;

    // Two-flop synchroniser for the asynchronous pins.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pins_in;
            sync2_q <= sync1_q;
        end
    end

    // Sample-tick counter and two-sample agreement debounce.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        upd      = '0;
        sample_d = sample_q;
        data_d   = data_q;
        if (tick) begin
            // A channel moves only when the previous sample already held the new level.
            upd      = ~(sync2_q ^ sample_q) & (sync2_q ^ data_q);
            data_d   = data_q ^ upd;
            sample_d = sync2_q;
        end
        rise   = upd & sync2_q;
        change = |upd;
    end

    // Address decode: full-width compare so aliases never hit.
    always_comb begin
        sel_data = (bus.addr == ADDR_DATA);
        sel_ctrl = (bus.addr == ADDR_CTRL);
        sel_edge = (bus.addr == ADDR_EDGE);
        rd_data  = bus.re & sel_data;
        wr_ctrl  = bus.we & sel_ctrl;
        wr_edge  = bus.we & sel_edge;
    end

    // Status, edge latch and interrupt next-state; every "set" is applied last so it wins.
    always_comb begin
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        edge_d  = edge_q;

        if (wr_ctrl) begin
            ie_d = bus.wdata[CTRL_IE];
            if (!bus.wdata[CTRL_OVR]) begin
                ovr_d = 1'b0;
            end
        end

        if (change) begin
            // A simultaneous DATA read consumed the old value, so it is not an overrun.
            if (ready_q && !rd_data) begin
                ovr_d = 1'b1;
            end
            ready_d = 1'b1;
        end else if (rd_data) begin
            ready_d = 1'b0;
        end

        if (wr_edge) begin
            edge_d = edge_q & ~bus.wdata[NCH-1:0];
        end
        edge_d = edge_d | rise;

        intr_d = ie_d & ready_d;
    end

    // Register state update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sample_q <= '0;
            data_q   <= '0;
            edge_q   <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ie_q     <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            data_q   <= data_d;
            edge_q   <= edge_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            ie_q     <= ie_d;
            intr_q   <= intr_d;
        end
    end

    // Read mux from current state: a same-cycle write is seen only after the edge.
    always_comb begin
        rdata_c = '0;
        if (bus.re) begin
            if (sel_data) begin
                rdata_c[NCH-1:0] = data_q;
            end else if (sel_ctrl) begin
                rdata_c[CTRL_READY] = ready_q;
                rdata_c[CTRL_OVR]   = ovr_q;
                rdata_c[CTRL_IE]    = ie_q;
            end else if (sel_edge) begin
                rdata_c[NCH-1:0] = edge_q;
            end
        end
    end

    assign bus.rdata    = rdata_c;
    assign intr         = intr_q;
    assign unused_wdata = ^bus.wdata;

endmodule

// File: tb/tb_debounced_input_dev.sv
// Self-checking bench for debounced_input_dev (NCH=4, DEB_CYCLES=4, active-low pins).
// Directed scenarios followed by randomized pins and bus traffic, all compared
// against a behavioural model that tracks pin history and tick times arithmetically.
module tb_debounced_input_dev;

    localparam int unsigned DBITS = 32;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEB   = 4;
    localparam logic [31:0] BASE   = 32'hFFFFF080;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_CTRL = BASE + 32'd4;
    localparam logic [31:0] A_EDGE = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pins;
    logic       intr;

    debounced_input_dev_if #(.DBITS(DBITS)) bus ();

    debounced_input_dev #(
        .DBITS      (DBITS),
        .NCH        (NCH),
        .BASE       (BASE),
        .DEB_CYCLES (DEB),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .pins  (pins),
        .intr  (intr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_n;          // clock edges since reset release
    logic [3:0] m_dly[$];     // logical pin levels seen at the last two edges
    logic [3:0] m_sample, m_data, m_edge;
    logic       m_ready, m_ovr, m_ie, m_intr;

    task automatic model_reset();
        m_n = 0;
        m_dly.delete();
        m_sample = '0; m_data = '0; m_edge = '0;
        m_ready = 0; m_ovr = 0; m_ie = 0; m_intr = 0;
    endtask

    // Synchronised level at the coming edge: the pins as they were two edges earlier.
    function automatic logic [3:0] m_sync();
        return (m_dly.size() == 2) ? m_dly[0] : 4'b0000;
    endfunction

    function automatic bit m_is_tick();
        return (m_n % DEB) == (DEB - 1);
    endfunction

    // Channels that will change at the coming edge.
    function automatic logic [3:0] m_upd();
        logic [3:0] s = m_sync();
        logic [3:0] u = '0;
        if (m_is_tick()) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] == m_sample[i] && s[i] != m_data[i]) u[i] = 1'b1;
            end
        end
        return u;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] addr, input logic re);
        logic [31:0] r = '0;
        if (re) begin
            if (addr == A_DATA)      r = {28'b0, m_data};
            else if (addr == A_CTRL) r = {23'b0, m_ie, 5'b0, m_ovr, 1'b0, m_ready};
            else if (addr == A_EDGE) r = {28'b0, m_edge};
        end
        return r;
    endfunction

    task automatic model_edge(input logic [3:0] raw, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic we, input logic re);
        logic [3:0] u    = m_upd();
        logic [3:0] s    = m_sync();
        logic [3:0] rise = u & s;
        bit         chg  = (u != 0);
        bit         rd   = re && (addr == A_DATA);
        if (we && addr == A_CTRL) begin
            m_ie = wdata[8];
            if (!wdata[2]) m_ovr = 0;
        end
        if (chg) begin
            if (m_ready && !rd) m_ovr = 1;
            m_ready = 1;
        end else if (rd) begin
            m_ready = 0;
        end
        if (we && addr == A_EDGE) m_edge = m_edge & ~wdata[3:0];
        m_edge = m_edge | rise;
        if (m_is_tick()) begin
            m_data   = (m_data & ~u) | (s & u);
            m_sample = s;
        end
        m_intr = m_ie & m_ready;
        m_dly.push_back(~raw);
        if (m_dly.size() > 2) void'(m_dly.pop_front());
        m_n++;
    endtask

    // ---------------- stimulus helpers (entered and left at negedge) ----------------
    logic [3:0]  cur_pins;
    logic [31:0] last_rd;

    task automatic cycle(input logic [3:0] p, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic re, input string tag);
        cur_pins  = p;
        pins      = p;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.we    = we;
        bus.re    = re;
        #1;
        last_rd = bus.rdata;
        if (re) check({tag, "/rdata"}, bus.rdata, m_rdata(addr, re));
        model_edge(p, addr, wdata, we, re);
        @(posedge clk);
        @(negedge clk);
        check({tag, "/intr"}, {31'b0, intr}, {31'b0, m_intr});
    endtask

    task automatic idle(input logic [3:0] p, input int n, input string tag);
        repeat (n) cycle(p, A_RSV, 32'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
        cycle(cur_pins, addr, data, 1'b1, 1'b0, tag);
    endtask

    task automatic rd_exp(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        cycle(cur_pins, addr, 32'h0, 1'b0, 1'b1, tag);
        check({tag, "/const"}, last_rd, exp);
    endtask

    initial begin
        bit          hit;
        logic [3:0]  p;
        logic [31:0] a, wd;
        int          op, hold;

        reset = 1'b1;
        pins = 4'b1111; cur_pins = 4'b1111;
        bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_intr", {31'b0, intr}, 32'h0);
        reset = 1'b0;

        // Reset state and idle pins
        rd_exp(A_DATA, 32'h0, "rst_data");
        rd_exp(A_CTRL, 32'h0, "rst_ctrl");
        rd_exp(A_EDGE, 32'h0, "rst_edge");
        idle(4'b1111, 20, "idle_hi");
        rd_exp(A_DATA, 32'h0, "idle_data");

        // Single key press
        idle(4'b1110, 12, "press0");
        rd_exp(A_CTRL, 32'h1, "press0_ctrl");
        rd_exp(A_EDGE, 32'h1, "press0_edge");
        rd_exp(A_DATA, 32'h1, "press0_data");
        rd_exp(A_CTRL, 32'h0, "press0_ctrl_clr");

        // Two-cycle glitch on pin 1 is filtered
        idle(4'b1100, 2, "glitch");
        idle(4'b1110, 12, "glitch_settle");
        rd_exp(A_DATA, 32'h1, "glitch_data");
        rd_exp(A_CTRL, 32'h0, "glitch_ctrl");
        rd_exp(A_EDGE, 32'h1, "glitch_edge");

        // Overrun after two unread changes, cleared by writing 0
        idle(4'b1100, 12, "chg1");
        idle(4'b1000, 12, "chg2");
        rd_exp(A_CTRL, 32'h5, "ovr_ctrl");
        wr(A_CTRL, 32'h0, "ovr_clr");
        rd_exp(A_CTRL, 32'h1, "ovr_clr_ctrl");
        rd_exp(A_DATA, 32'h7, "ovr_data");

        // Interrupt enable
        wr(A_CTRL, 32'h100, "ie_set");
        rd_exp(A_CTRL, 32'h100, "ie_ctrl");
        idle(4'b0000, 12, "ie_chg");
        check("ie_intr_hi", {31'b0, intr}, 32'h1);
        rd_exp(A_CTRL, 32'h101, "ie_ctrl_rdy");
        rd_exp(A_DATA, 32'hF, "ie_read");
        check("ie_intr_lo", {31'b0, intr}, 32'h0);

        // EDGE W1C
        wr(A_EDGE, 32'hF, "edge_clr");
        rd_exp(A_EDGE, 32'h0, "edge_clr_rd");
        idle(4'b1111, 12, "edge_release");
        rd_exp(A_DATA, 32'h0, "edge_release_data");
        idle(4'b1100, 12, "edge_press");
        rd_exp(A_EDGE, 32'h3, "edge_3");
        wr(A_EDGE, 32'h1, "edge_w1c");
        rd_exp(A_EDGE, 32'h2, "edge_2");
        idle(4'b1101, 12, "edge_rel0");

        // W1C on the same edge as a new rise of bit 0: the set wins
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if ((m_upd() & m_sync() & 4'b0001) != 0) begin
                cycle(4'b1100, A_EDGE, 32'h1, 1'b1, 1'b0, "edge_race");
                hit = 1;
            end else begin
                idle(4'b1100, 1, "edge_wait");
            end
        end
        check("edge_race_seen", {31'b0, hit}, 32'h1);
        rd_exp(A_EDGE, 32'h3, "edge_race_rd");

        // Asynchronous reset between clock edges
        idle(4'b0110, 2, "pre_rst");
        #2;
        reset = 1'b1;
        #1;
        bus.we = 1'b0; bus.re = 1'b1;
        bus.addr = A_DATA; #1; check("mid_rst_data", bus.rdata, 32'h0);
        bus.addr = A_CTRL; #1; check("mid_rst_ctrl", bus.rdata, 32'h0);
        bus.addr = A_EDGE; #1; check("mid_rst_edge", bus.rdata, 32'h0);
        check("mid_rst_intr", {31'b0, intr}, 32'h0);
        bus.re = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rd_exp(A_DATA, 32'h0, "post_rst_data");

        // Randomized pins and bus traffic
        p = cur_pins;
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 2) == 0) p = 4'($urandom);
            hold = $urandom_range(1, 8);
            repeat (hold) begin
                op = $urandom_range(0, 9);
                case ($urandom_range(0, 4))
                    0:       a = A_DATA;
                    1:       a = A_CTRL;
                    2:       a = A_EDGE;
                    3:       a = A_RSV;
                    default: a = $urandom;
                endcase
                wd = $urandom;
                if (op <= 3)      cycle(p, A_RSV, 32'h0, 1'b0, 1'b0, "rnd_idle");
                else if (op <= 6) cycle(p, a, 32'h0, 1'b0, 1'b1, "rnd_rd");
                else if (op <= 8) cycle(p, a, wd, 1'b1, 1'b0, "rnd_wr");
                else              cycle(p, a, wd, 1'b1, 1'b1, "rnd_rw");
            end
        end
        rd_exp(A_RSV, 32'h0, "rsv_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
